// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for a lw/sw/R-type/beq/j core; addi is added when MC_CONTROL_ADDI_EN is defined.
// Latency: outputs decode combinationally from state (plus opcode/funct/zero/mem_ready qualifiers); 3-5 cycles per instruction.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; IR/PC strobes fire only in the completing cycle.
module mc_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    // run_q keeps every output quiet until the first edge after reset release
    logic       run_q, run_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'd0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            run_q    <= run_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        run_d       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        alu_control = 4'b0000;
        illegal     = 1'b0;

        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                    opcode_d    = opcode;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADDR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
                        OP_ADDI:      state_d = S_ADDIEX;
`endif
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADDR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                    // direction comes from the opcode captured in DECODE, not the live bus
                    state_d     = (opcode_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    state_d   = S_ALUWB;
                    case (funct)
                        FN_ADD: alu_control = ALU_ADD;
                        FN_SUB: alu_control = ALU_SUB;
                        FN_AND: alu_control = ALU_AND;
                        FN_OR:  alu_control = ALU_OR;
                        FN_SLT: alu_control = ALU_SLT;
                        default: begin
                            alu_control = ALU_ADD;
                            illegal     = 1'b1;
                            state_d     = S_FETCH;
                        end
                    endcase
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_source   = 2'b01;
                    pc_write    = zero;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end
`ifdef MC_CONTROL_ADDI_EN
                S_ADDIEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                    state_d     = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
`endif
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
